// File: rtl/verilab_gpio_arbiter.sv
// Round-robin arbiter sharing the GPIO out/en/in register bank between NUM_REQ
// register requesters, with a registered response channel and a 2-flop input synchroniser.
module verilab_gpio_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned GPIO_W  = 32,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [2*NUM_REQ-1:0]        addr,
    input  logic [GPIO_W*NUM_REQ-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        rsp_valid,
    output logic [ID_W-1:0]             rsp_id,
    output logic [GPIO_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    input  logic [GPIO_W-1:0]           gpio_in,
    output logic [GPIO_W-1:0]           gpio_out,
    output logic [GPIO_W-1:0]           gpio_en
);

    localparam logic [1:0] ADDR_OUT = 2'd0;
    localparam logic [1:0] ADDR_EN  = 2'd1;
    localparam logic [1:0] ADDR_IN  = 2'd2;
    localparam logic [1:0] ADDR_TGL = 2'd3;

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   next_ptr;
    logic              gnt_any;
    logic              active;
    logic              sel_we;
    logic [1:0]        sel_addr;
    logic [GPIO_W-1:0] sel_wdata;
    logic [GPIO_W-1:0] rdata_c;
    logic              err_c;
    logic [GPIO_W-1:0] sync1;
    logic [GPIO_W-1:0] sync2;

    // Search from ptr upward with wrap; the lowest rotation offset with req set wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!gnt_any && req[i] && (i == (32'(ptr) + off) % NUM_REQ)) begin
                    gnt_any = 1'b1;
                    gnt_idx = ID_W'(i);
                end
            end
        end
    end

    assign active   = gnt_any && !reset;
    assign next_ptr = ID_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);

    // One-hot grant and payload mux of the winning requester.
    always_comb begin
        gnt       = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt[i] = active && (gnt_idx == ID_W'(i));
            if (gnt_idx == ID_W'(i)) begin
                sel_we    = we[i];
                sel_addr  = addr[2*i +: 2];
                sel_wdata = wdata[GPIO_W*i +: GPIO_W];
            end
        end
    end

    // Read data reflects register state before this cycle's write.
    always_comb begin
        rdata_c = '0;
        err_c   = 1'b0;
        case (sel_addr)
            ADDR_OUT: if (!sel_we) rdata_c = gpio_out;
            ADDR_EN:  if (!sel_we) rdata_c = gpio_en;
            ADDR_IN: begin
                if (sel_we) err_c   = 1'b1;
                else        rdata_c = sync2;
            end
            default:  err_c = !sel_we;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            sync1     <= '0;
            sync2     <= '0;
            gpio_out  <= '0;
            gpio_en   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            sync1     <= gpio_in;
            sync2     <= sync1;
            rsp_valid <= active;
            if (active) begin
                ptr       <= next_ptr;
                rsp_id    <= gnt_idx;
                rsp_rdata <= rdata_c;
                rsp_err   <= err_c;
                if (sel_we) begin
                    case (sel_addr)
                        ADDR_OUT: gpio_out <= sel_wdata;
                        ADDR_EN:  gpio_en  <= sel_wdata;
                        ADDR_TGL: gpio_out <= gpio_out ^ sel_wdata;
                        default:  ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_verilab_gpio_arbiter.sv
// Bench for verilab_gpio_arbiter: directed scenarios then random traffic,
// all checked against a transaction-level model of the register bank and arbiter.
module tb_verilab_gpio_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned GPIO_W  = 32;
    localparam int unsigned ID_W    = 1;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [2*NUM_REQ-1:0]      addr;
    logic [GPIO_W*NUM_REQ-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [GPIO_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [GPIO_W-1:0]         gpio_in;
    logic [GPIO_W-1:0]         gpio_out;
    logic [GPIO_W-1:0]         gpio_en;

    always #5 clk = ~clk;

    verilab_gpio_arbiter #(.NUM_REQ(NUM_REQ), .GPIO_W(GPIO_W), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_en(gpio_en)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: pointer, register values, history of sampled pad values.
    int          m_ptr;
    logic [31:0] m_out, m_en;
    logic [31:0] m_hist[$];
    logic        m_valid;
    int          m_id;
    logic [31:0] m_rdata;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int pick();
        int k;
        for (int off = 0; off < int'(NUM_REQ); off++) begin
            k = (m_ptr + off) % int'(NUM_REQ);
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic set_lane(input int i, input logic r, input logic w,
                            input logic [1:0] a, input logic [31:0] d);
        req[i]            = r;
        we[i]             = w;
        addr[2*i +: 2]    = a;
        wdata[32*i +: 32] = d;
    endtask

    // Called at a negedge with inputs set; checks grant, advances one clock, checks results.
    task automatic cycle();
        int k;
        logic [1:0] a;
        logic [31:0] d;
        logic [NUM_REQ-1:0] eg;
        #1;
        k = reset ? -1 : pick();
        eg = '0;
        if (k >= 0) eg[k] = 1'b1;
        check("gnt", 32'(gnt), 32'(eg));
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_out = '0; m_en = '0; m_hist = '{32'h0, 32'h0};
            m_valid = 1'b0; m_id = 0; m_rdata = '0; m_err = 1'b0;
        end else begin
            m_valid = (k >= 0);
            if (k >= 0) begin
                a = addr[2*k +: 2];
                d = wdata[32*k +: 32];
                m_id    = k;
                m_err   = (we[k] && a == 2'd2) || (!we[k] && a == 2'd3);
                m_rdata = '0;
                if (!we[k]) begin
                    case (a)
                        2'd0:    m_rdata = m_out;
                        2'd1:    m_rdata = m_en;
                        2'd2:    m_rdata = m_hist[0];
                        default: m_rdata = '0;
                    endcase
                end else begin
                    case (a)
                        2'd0:    m_out = d;
                        2'd1:    m_en  = d;
                        2'd3:    m_out = m_out ^ d;
                        default: ;
                    endcase
                end
                m_ptr = (k + 1) % int'(NUM_REQ);
            end
            m_hist.push_back(gpio_in);
            void'(m_hist.pop_front());
        end
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_err", 32'(rsp_err), 32'(m_err));
        end
        check("gpio_out", gpio_out, m_out);
        check("gpio_en", gpio_en, m_en);
    endtask

    initial begin
        reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; gpio_in = '0;
        m_ptr = 0; m_out = '0; m_en = '0; m_hist = '{32'h0, 32'h0};
        m_valid = 1'b0; m_id = 0; m_rdata = '0; m_err = 1'b0;
        @(negedge clk);

        // Reset with all requests high.
        req = '1;
        cycle();
        cycle();
        check("rst_out", gpio_out, 32'h0);
        check("rst_en", gpio_en, 32'h0);
        reset = 1'b0;
        req = '0;

        // Write OUT and EN from requester 0, read OUT back.
        set_lane(0, 1'b1, 1'b1, 2'd0, 32'hA5A5_0001); cycle();
        set_lane(0, 1'b1, 1'b1, 2'd1, 32'hFFFF_0000); cycle();
        set_lane(0, 1'b1, 1'b0, 2'd0, 32'h0);         cycle();
        check("wr_rd_data", rsp_rdata, 32'hA5A5_0001);
        check("wr_rd_id", 32'(rsp_id), 32'd0);
        check("wr_rd_err", 32'(rsp_err), 32'd0);
        check("wr_en", gpio_en, 32'hFFFF_0000);

        // Bring the pointer back to 0, then alternate grants under continuous requests.
        set_lane(0, 1'b0, 1'b0, 2'd0, 32'h0);
        set_lane(1, 1'b1, 1'b0, 2'd1, 32'h0);
        cycle();
        set_lane(0, 1'b1, 1'b0, 2'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_id", 32'(rsp_id), 32'(i % 2));
        end
        req = '0;

        // Toggle and illegal accesses.
        set_lane(0, 1'b1, 1'b1, 2'd0, 32'h0000_00FF); cycle();
        set_lane(0, 1'b1, 1'b1, 2'd3, 32'h0000_0F0F); cycle();
        check("tgl_out", gpio_out, 32'h0000_0FF0);
        set_lane(0, 1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF); cycle();
        check("wr_in_err", 32'(rsp_err), 32'd1);
        check("wr_in_out", gpio_out, 32'h0000_0FF0);
        set_lane(0, 1'b1, 1'b0, 2'd3, 32'h0); cycle();
        check("rd_tgl_err", 32'(rsp_err), 32'd1);
        check("rd_tgl_data", rsp_rdata, 32'h0);

        // Input synchroniser latency.
        req = '0;
        gpio_in = 32'h1234_5678;
        cycle();
        set_lane(0, 1'b1, 1'b0, 2'd2, 32'h0); cycle();
        check("sync_t1", rsp_rdata, 32'h0);
        cycle();
        check("sync_t2", rsp_rdata, 32'h1234_5678);

        // Reset in the cycle after a grant.
        set_lane(0, 1'b1, 1'b1, 2'd0, 32'hDEAD_BEEF); cycle();
        reset = 1'b1;
        req = '1;
        cycle();
        check("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_out", gpio_out, 32'h0);
        reset = 1'b0;
        set_lane(0, 1'b1, 1'b0, 2'd0, 32'h0);
        set_lane(1, 1'b1, 1'b0, 2'd0, 32'h0);
        #1;
        check("rst_mid_ptr", 32'(gnt), 32'd1);
        cycle();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            req   = NUM_REQ'($urandom);
            we    = NUM_REQ'($urandom);
            addr  = (2*NUM_REQ)'($urandom);
            wdata = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) gpio_in = $urandom;
            reset = ($urandom_range(0, 59) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
